// File: rtl/iq_decimator.sv
// iq_decimator: integrate-and-dump decimator for packed 16-bit I/Q samples.
// Sums DECIM samples per channel, scales by 1/DECIM (arithmetic shift by
// log2(DECIM)) and emits one 64-bit word: real in [31:0], imag in [63:32],
// each a sign-extended 16-bit result. An input tlast closes a partial block.
// Optional build macro IQ_DECIM_ROUND_EN: round half toward +inf before the
// shift instead of truncating toward -inf.

module iq_decimator #(
   parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64,
   parameter int unsigned DECIM                  = 8
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_areset,
   input  logic                                s00_axis_tvalid,
   output logic                                s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                                s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   output logic                                m00_axis_tvalid,
   input  logic                                m00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic                                m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

   localparam int unsigned L    = $clog2(DECIM);
   localparam int unsigned AccW = 16 + L;
   localparam logic [L:0]  CntLast = (L+1)'(DECIM - 1);

   logic signed [AccW-1:0] acc_re_q, acc_re_d;
   logic signed [AccW-1:0] acc_im_q, acc_im_d;
   logic        [L:0]      cnt_q, cnt_d;
   logic signed [15:0]     out_re_q, out_re_d;
   logic signed [15:0]     out_im_q, out_im_d;
   logic                   m_valid_q, m_valid_d;
   logic                   m_last_q, m_last_d;

   logic signed [15:0]     smp_re, smp_im;
   logic signed [AccW-1:0] sum_re, sum_im;
   logic signed [AccW-1:0] rnd_re, rnd_im;
   logic                   accept, dump;
   logic                   unused_tstrb;

   assign unused_tstrb = ^s00_axis_tstrb;

   assign smp_re = s00_axis_tdata[15:0];
   assign smp_im = s00_axis_tdata[31:16];

   // Full-width block sums including the sample being accepted this cycle.
   assign sum_re = acc_re_q + AccW'(smp_re);
   assign sum_im = acc_im_q + AccW'(smp_im);

`ifdef IQ_DECIM_ROUND_EN
   // Bias by half an LSB of the result; the sum cannot overflow AccW since
   // |sum| <= 32768 * DECIM and the bias is only DECIM/2.
   assign rnd_re = sum_re + AccW'(DECIM / 2);
   assign rnd_im = sum_im + AccW'(DECIM / 2);
`else
   assign rnd_re = sum_re;
   assign rnd_im = sum_im;
`endif

   // Input stalls only while a produced output is held by the sink.
   assign s00_axis_tready = !(m_valid_q && !m00_axis_tready);
   assign accept          = s00_axis_tvalid && s00_axis_tready;
   assign dump            = accept && ((cnt_q == CntLast) || s00_axis_tlast);

   // Next-state: accumulate, dump into the output register, retire on handshake.
   always_comb begin
      acc_re_d  = acc_re_q;
      acc_im_d  = acc_im_q;
      cnt_d     = cnt_q;
      out_re_d  = out_re_q;
      out_im_d  = out_im_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;

      if (m_valid_q && m00_axis_tready) begin
         m_valid_d = 1'b0;
      end

      if (dump) begin
         acc_re_d  = '0;
         acc_im_d  = '0;
         cnt_d     = '0;
         out_re_d  = 16'(rnd_re >>> L);
         out_im_d  = 16'(rnd_im >>> L);
         m_valid_d = 1'b1;
         m_last_d  = s00_axis_tlast;
      end else if (accept) begin
         acc_re_d = sum_re;
         acc_im_d = sum_im;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         acc_re_q  <= '0;
         acc_im_q  <= '0;
         cnt_q     <= '0;
         out_re_q  <= '0;
         out_im_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         acc_re_q  <= acc_re_d;
         acc_im_q  <= acc_im_d;
         cnt_q     <= cnt_d;
         out_re_q  <= out_re_d;
         out_im_q  <= out_im_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
      end
   end

   assign m00_axis_tvalid = m_valid_q;
   assign m00_axis_tlast  = m_last_q;
   assign m00_axis_tstrb  = '1;
   assign m00_axis_tdata  = {{16{out_im_q[15]}}, out_im_q, {16{out_re_q[15]}}, out_re_q};

endmodule

// File: tb/tb_iq_decimator.sv
// Scoreboard bench for iq_decimator (DECIM = 8). Honours IQ_DECIM_ROUND_EN.

module tb_iq_decimator;

   localparam int DECIM = 8;
   localparam int L     = 3;

   typedef struct packed {
      logic        last;
      logic [63:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        areset;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] s_tdata;
   logic        s_tlast;
   logic [3:0]  s_tstrb;
   logic        m_tvalid;
   logic        m_tready;
   logic [63:0] m_tdata;
   logic        m_tlast;
   logic [7:0]  m_tstrb;

   logic ready_ctl;
   logic rnd_bit;
   bit   rand_bp;

   int   total = 0;
   int   bad   = 0;
   int   acc_re, acc_im, cnt;
   int   n_out = 0;
   int   n_exp = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
   assign m_tready = rand_bp ? rnd_bit : ready_ctl;

   iq_decimator #(
      .C_S00_AXIS_TDATA_WIDTH(32),
      .C_M00_AXIS_TDATA_WIDTH(64),
      .DECIM                 (DECIM)
   ) dut (
      .s00_axis_aclk  (clk),
      .s00_axis_areset(areset),
      .s00_axis_tvalid(s_tvalid),
      .s00_axis_tready(s_tready),
      .s00_axis_tdata (s_tdata),
      .s00_axis_tlast (s_tlast),
      .s00_axis_tstrb (s_tstrb),
      .m00_axis_tvalid(m_tvalid),
      .m00_axis_tready(m_tready),
      .m00_axis_tdata (m_tdata),
      .m00_axis_tlast (m_tlast),
      .m00_axis_tstrb (m_tstrb)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model of one accepted sample; pushes the expected word on a dump.
   task automatic model_accept(input int re, input int im, input bit last, output bit dmp);
      int   sr, si;
      exp_t e;
      sr  = acc_re + re;
      si  = acc_im + im;
      cnt = cnt + 1;
      dmp = (cnt == DECIM) || last;
      if (dmp) begin
`ifdef IQ_DECIM_ROUND_EN
         sr = sr + DECIM / 2;
         si = si + DECIM / 2;
`endif
         sr     = sr >>> L;
         si     = si >>> L;
         e.last = last;
         e.data = {si, sr};
         sb.push_back(e);
         n_exp++;
         acc_re = 0;
         acc_im = 0;
         cnt    = 0;
      end else begin
         acc_re = sr;
         acc_im = si;
      end
   endtask

   // Drive one sample and hold it until accepted (bounded wait).
   task automatic send(input int re, input int im, input bit last);
      int waited = 0;
      bit done   = 0;
      bit dmp    = 0;
      s_tvalid = 1'b1;
      s_tdata  = {im[15:0], re[15:0]};
      s_tlast  = last;
      while (!done) begin
         @(negedge clk);
         if (s_tready) begin
            model_accept(re, im, last, dmp);
            done = 1;
         end else if (++waited > 1000) begin
            check_val("accept_timeout", 64'(waited), 64'(0));
            done = 1;
         end
         @(posedge clk);
         #1;
         if (done && dmp) check_val("latency_valid", 64'(m_tvalid), 64'(1));
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic do_reset();
      areset   = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = {16'sd999, 16'sd999};
      s_tlast  = 1'b0;
      @(posedge clk);
      #1;
      areset   = 1'b0;
      s_tvalid = 1'b0;
      acc_re   = 0;
      acc_im   = 0;
      cnt      = 0;
   endtask

   task automatic drain();
      int waited = 0;
      while (sb.size() != 0 && waited < 300) begin
         @(posedge clk);
         waited++;
      end
      #1;
      check_val("drain_left", 64'(sb.size()), 64'(0));
   endtask

   // Output monitor: pop and compare on every completed handshake.
   always @(negedge clk) begin
      if (!areset && m_tvalid && m_tready) begin
         n_out++;
         if (sb.size() == 0) begin
            check_val("extra_out", m_tdata, 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val("out_data", m_tdata, e.data);
            check_val("out_last", 64'(m_tlast), 64'(e.last));
            check_val("out_strb", 64'(m_tstrb), 64'hFF);
         end
      end
   end

   initial begin
      int   re, im;
      bit   lst;
      exp_t held;
      areset    = 1'b1;
      s_tvalid  = 1'b0;
      s_tdata   = '0;
      s_tlast   = 1'b0;
      s_tstrb   = 4'hF;
      ready_ctl = 1'b1;
      rand_bp   = 1'b0;
      acc_re    = 0;
      acc_im    = 0;
      cnt       = 0;
      repeat (2) @(posedge clk);
      #1;
      areset = 1'b0;

      // Reset state
      check_val("rst_valid", 64'(m_tvalid), 64'(0));
      check_val("rst_data", m_tdata, 64'(0));
      check_val("rst_last", 64'(m_tlast), 64'(0));
      check_val("rst_strb", 64'(m_tstrb), 64'hFF);
      check_val("rst_ready", 64'(s_tready), 64'(1));

      // Constant input: two blocks of (1000, -1000)
      for (int i = 0; i < 16; i++) send(1000, -1000, 1'b0);
      drain();

      // Rounding, positive then negative sum of magnitude 4
      for (int i = 0; i < 8; i++) send((i < 4) ? 1 : 0, (i < 4) ? -1 : 0, 1'b0);
      drain();

      // Full scale, no wrap
      for (int i = 0; i < 8; i++) send(32767, -32768, 1'b0);
      drain();

      // Partial block closed by tlast, then a normal block
      for (int i = 0; i < 3; i++) send(800, -800, i == 2);
      for (int i = 0; i < 8; i++) send(10 * i, -7 * i, 1'b0);
      drain();

      // Backpressure: hold the first dump, then release
      ready_ctl = 1'b0;
      for (int i = 0; i < 8; i++) send(100 + i, 200 - i, 1'b0);
      held     = sb[0];
      s_tvalid = 1'b1;
      s_tdata  = {16'sd5, 16'sd7};
      s_tlast  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("bp_ready", 64'(s_tready), 64'(0));
         check_val("bp_valid", 64'(m_tvalid), 64'(1));
         check_val("bp_data", m_tdata, held.data);
      end
      @(posedge clk);
      #1;
      ready_ctl = 1'b1;
      send(7, 5, 1'b0);
      check_val("bp_ready_after", 64'(s_tready), 64'(1));
      for (int i = 0; i < 7; i++) send(3, -3, 1'b0);
      drain();

      // Random data, random tlast, random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 64; i++) begin
         re  = int'($urandom_range(0, 65535)) - 32768;
         im  = int'($urandom_range(0, 65535)) - 32768;
         lst = ($urandom_range(0, 7) == 0);
         send(re, im, lst);
      end
      if (cnt != 0) begin
         for (int i = cnt; i < DECIM; i++) send(1, 1, 1'b0);
      end
      drain();
      rand_bp = 1'b0;
      @(posedge clk);
      #1;

      // Reset mid-block: partial sum and the reset cycle's input are dropped
      for (int i = 0; i < 5; i++) send(50, 50, 1'b0);
      do_reset();
      check_val("midrst_valid", 64'(m_tvalid), 64'(0));
      check_val("midrst_data", m_tdata, 64'(0));
      check_val("midrst_ready", 64'(s_tready), 64'(1));
      for (int i = 0; i < 8; i++) send(100, 100, 1'b0);
      drain();
      repeat (4) @(posedge clk);
      #1;

      check_val("out_count", 64'(n_out), 64'(n_exp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
